// File: rtl/bound_flasher_ctrlfsm.sv
// rtl/bound_flasher_ctrlfsm.sv - Control FSM sequencing the bound flasher up/down phases
// Define BOUND_FLASHER_FLICK_SYNC_EN to route flick through a 2-flop synchronizer.
`timescale 1ns/1ps
module bound_flasher_ctrlfsm #(
  parameter logic [4:0] P_LOW = 5'd6,
  parameter logic [4:0] P_MID = 5'd11,
  parameter logic [4:0] P_MAX = 5'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flick,
  input  logic [4:0] state,
  output logic       enb,
  output logic       ison,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP_A = 3'd1,
    DN_A = 3'd2,
    UP_B = 3'd3,
    DN_B = 3'd4,
    UP_C = 3'd5,
    DN_C = 3'd6,
    CLR  = 3'd7
  } phase_e;

  phase_e phase_q, phase_d;
  logic   flick_s;

`ifdef BOUND_FLASHER_FLICK_SYNC_EN
  logic [1:0] flick_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flick_sync_q <= 2'b00;
    end else begin
      flick_sync_q <= {flick_sync_q[0], flick};
    end
  end

  assign flick_s = flick_sync_q[1];
`else
  assign flick_s = flick;
`endif

  // Step decisions are combinational so the output FSM moves on the same edge the phase advances.
  always_comb begin
    enb     = 1'b0;
    ison    = 1'b0;
    phase_d = phase_q;
    unique case (phase_q)
      IDLE: begin
        if (state != 5'd0) begin
          phase_d = CLR;
        end else if (flick_s) begin
          phase_d = UP_A;
        end
      end
      UP_A, UP_B, UP_C: begin
        if (state >= P_MAX) begin
          phase_d = CLR;
        end else begin
          enb  = 1'b1;
          ison = 1'b1;
          if (phase_q == UP_B && state == P_LOW && flick_s) begin
            ison    = 1'b0;
            phase_d = DN_A;
          end else if (phase_q == UP_C && state == P_MID && flick_s) begin
            ison    = 1'b0;
            phase_d = DN_B;
          end else if (phase_q == UP_A && state == P_LOW - 5'd1) begin
            phase_d = DN_A;
          end else if (phase_q == UP_B && state == P_MID - 5'd1) begin
            phase_d = DN_B;
          end else if (phase_q == UP_C && state == P_MAX - 5'd1) begin
            phase_d = DN_C;
          end
        end
      end
      DN_A, DN_B, DN_C, CLR: begin
        if (state == 5'd0) begin
          phase_d = IDLE;
        end else if (state > P_MAX && phase_q != CLR) begin
          phase_d = CLR;
        end else begin
          // CLR keeps draining from any count so an oversized preload still reaches zero.
          enb = 1'b1;
          if (phase_q == DN_A && state == 5'd1) begin
            phase_d = UP_B;
          end else if (phase_q == DN_B && state == P_LOW + 5'd1) begin
            phase_d = UP_C;
          end else if ((phase_q == DN_C || phase_q == CLR) && state == 5'd1) begin
            phase_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= IDLE;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule
